// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register chain:
// per-stage occupancy type and the chain-wide occupancy width helper.
package pipe_pkg;

   typedef logic [1:0] stage_occ_t;

   function automatic int occ_w(input int stages);
      return $clog2(2 * stages + 1);
   endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One elastic stage: main register M feeds downstream, skid register S absorbs
// the word that arrives in the cycle downstream stalls. Upstream ready is ~sv only.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output stage_occ_t       occ
);

   logic             mv_q, mv_d;
   logic             sv_q, sv_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             in_fire;

   assign in_fire   = in_valid & ~sv_q;
   assign in_ready  = ~sv_q;
   assign out_valid = mv_q;
   assign out_data  = m_q;
   assign occ       = {1'b0, mv_q} + {1'b0, sv_q};

   // Next-state selection; flush overrides every handshake but leaves data alone.
   always_comb begin
      mv_d = mv_q;
      sv_d = sv_q;
      m_d  = m_q;
      s_d  = s_q;
      if (flush) begin
         mv_d = 1'b0;
         sv_d = 1'b0;
      end else if (sv_q) begin
         if (out_ready) begin
            m_d  = s_q;
            mv_d = 1'b1;
            sv_d = 1'b0;
         end else begin
            sv_d = 1'b1;
         end
      end else if (in_fire) begin
         if (!mv_q || out_ready) begin
            m_d  = in_data;
            mv_d = 1'b1;
         end else begin
            s_d  = in_data;
            sv_d = 1'b1;
         end
      end else if (mv_q && out_ready) begin
         mv_d = 1'b0;
      end else begin
         mv_d = mv_q;
      end
   end

   // State registers; reset also returns the data registers to RESET_VAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv_q <= 1'b0;
         sv_q <= 1'b0;
         m_q  <= RESET_VAL;
         s_q  <= RESET_VAL;
      end else begin
         mv_q <= mv_d;
         sv_q <= sv_d;
         m_q  <= m_d;
         s_q  <= s_d;
      end
   end

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of STAGES elastic skid stages; all stage boundaries are register-to-register
// in the ready direction, and occupancy is the sum of the per-stage counts.
module pipe_reg_chain
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               STAGES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [occ_w(STAGES)-1:0]   occupancy
);

   localparam int OCC_W = occ_w(STAGES);

   logic             vld [STAGES+1];
   logic             rdy [STAGES+1];
   logic [WIDTH-1:0] dat [STAGES+1];
   stage_occ_t       stage_occ [STAGES];
   logic [OCC_W-1:0] occ_sum;

   assign vld[0]      = in_valid;
   assign dat[0]      = in_data;
   assign in_ready    = rdy[0];
   assign rdy[STAGES] = out_ready;
   assign out_valid   = vld[STAGES];
   assign out_data    = dat[STAGES];

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      pipe_skid_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .in_valid  (vld[g]),
         .in_ready  (rdy[g]),
         .in_data   (dat[g]),
         .out_valid (vld[g+1]),
         .out_ready (rdy[g+1]),
         .out_data  (dat[g+1]),
         .occ       (stage_occ[g])
      );
   end

   // Total words held across all stages.
   always_comb begin
      occ_sum = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_sum = occ_sum + OCC_W'(stage_occ[i]);
      end
   end

   assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench: three chains (STAGES=1,2,3) exercised with a vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_pipe_reg_chain;

   localparam logic [7:0] RV = 8'hE7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic       fl [1:3];
   logic       iv [1:3];
   logic       ordy [1:3];
   logic       irdy [1:3];
   logic       ov [1:3];
   logic [7:0] id [1:3];
   logic [7:0] od [1:3];
   logic [1:0] occ1;
   logic [2:0] occ2;
   logic [2:0] occ3;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(8), .STAGES(1), .RESET_VAL(RV)) u_d1 (
      .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
      .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
      .occupancy(occ1));
   pipe_reg_chain #(.WIDTH(8), .STAGES(2), .RESET_VAL(RV)) u_d2 (
      .clk(clk), .rst_n(rst_n), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
      .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
      .occupancy(occ2));
   pipe_reg_chain #(.WIDTH(8), .STAGES(3), .RESET_VAL(RV)) u_d3 (
      .clk(clk), .rst_n(rst_n), .flush(fl[3]), .in_valid(iv[3]), .in_ready(irdy[3]),
      .in_data(id[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]),
      .occupancy(occ3));

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       r;
      logic       f;
      logic       e_irdy;
      logic       e_ov;
      logic [7:0] e_od;
      int         e_occ;
   } vec_t;

   vec_t tbl [18];

   function automatic int occ_of(input int k);
      if (k == 1) return int'(occ1);
      if (k == 2) return int'(occ2);
      return int'(occ3);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic drive(input int k, input logic v, input logic [7:0] d,
                        input logic r, input logic f);
      iv[k] = v; id[k] = d; ordy[k] = r; fl[k] = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input int k, input string tag);
      chk({tag, "_ov"},   int'(ov[k]),   0);
      chk({tag, "_od"},   int'(od[k]),   int'(RV));
      chk({tag, "_occ"},  occ_of(k),     0);
      chk({tag, "_irdy"}, int'(irdy[k]), 1);
   endtask

   initial begin
      logic [7:0] q1 [$];
      logic [7:0] q3 [$];
      int acc_cnt, out_cnt, exp_od, act_od, act_v, exp_v;
      logic v, r, acc, pop;
      logic [7:0] d;

      for (int k = 1; k <= 3; k++) drive(k, 1'b0, 8'h00, 1'b0, 1'b0);

      // reset state
      #12;
      chk_reset(1, "rst_s1");
      chk_reset(2, "rst_s2");
      chk_reset(3, "rst_s3");
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // STAGES=3 streaming, drain, fill to full, drain in order
      tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
      tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2};
      tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
      tbl[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
      tbl[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2};
      tbl[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3};
      tbl[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4};
      tbl[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 5};
      tbl[11] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 6};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 5};
      tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 4};
      tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 3};
      tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 2};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h06, 1};
      tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
      for (int i = 0; i < 18; i++) begin
         drive(3, tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
         tick();
         chk($sformatf("tbl%0d_irdy", i), int'(irdy[3]), int'(tbl[i].e_irdy));
         chk($sformatf("tbl%0d_ov", i),   int'(ov[3]),   int'(tbl[i].e_ov));
         if (tbl[i].e_ov) chk($sformatf("tbl%0d_od", i), int'(od[3]), int'(tbl[i].e_od));
         chk($sformatf("tbl%0d_occ", i),  occ_of(3),     tbl[i].e_occ);
      end
      drive(3, 1'b0, 8'h00, 1'b0, 1'b0);

      // STAGES=2 flush with three words held and a word offered at the flush edge
      drive(2, 1'b1, 8'h31, 1'b0, 1'b0); tick();
      drive(2, 1'b1, 8'h32, 1'b0, 1'b0); tick();
      drive(2, 1'b1, 8'h33, 1'b0, 1'b0); tick();
      chk("fl_pre_occ", occ_of(2), 3);
      drive(2, 1'b1, 8'hAA, 1'b0, 1'b1); tick();
      chk("fl_occ", occ_of(2), 0);
      chk("fl_ov", int'(ov[2]), 0);
      chk("fl_irdy", int'(irdy[2]), 1);
      drive(2, 1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_quiet_ov", int'(ov[2]), 0);
      end
      drive(2, 1'b1, 8'h44, 1'b0, 1'b0); tick();
      drive(2, 1'b0, 8'h00, 1'b0, 1'b0); tick();
      chk("fl_after_ov", int'(ov[2]), 1);
      chk("fl_after_od", int'(od[2]), 8'h44);
      drive(2, 1'b0, 8'h00, 1'b1, 1'b0); tick();
      chk("fl_after_occ", occ_of(2), 0);

      // STAGES=1 skid path
      drive(1, 1'b1, 8'h5A, 1'b0, 1'b0); tick();
      chk("sk1_occ", occ_of(1), 1);
      chk("sk1_od", int'(od[1]), 8'h5A);
      drive(1, 1'b1, 8'hA5, 1'b0, 1'b0); tick();
      chk("sk2_occ", occ_of(1), 2);
      chk("sk2_irdy", int'(irdy[1]), 0);
      chk("sk2_od", int'(od[1]), 8'h5A);
      drive(1, 1'b0, 8'h00, 1'b1, 1'b0); tick();
      chk("sk3_ov", int'(ov[1]), 1);
      chk("sk3_od", int'(od[1]), 8'hA5);
      chk("sk3_occ", occ_of(1), 1);
      chk("sk3_irdy", int'(irdy[1]), 1);
      tick();
      chk("sk4_occ", occ_of(1), 0);

      // STAGES=1 random traffic against a 2-deep queue model
      acc_cnt = 0; out_cnt = 0;
      for (int c = 0; c < 1000; c++) begin
         v = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 3) != 0);
         d = 8'($urandom);
         acc = v && (q1.size() < 2);
         pop = r && (q1.size() > 0);
         drive(1, v, d, r, 1'b0);
         tick();
         if (pop) begin
            void'(q1.pop_front());
            out_cnt++;
         end
         if (acc) begin
            q1.push_back(d);
            acc_cnt++;
         end
         exp_od = (q1.size() > 0) ? int'(q1[0]) : 0;
         act_od = (q1.size() > 0) ? int'(od[1]) : 0;
         act_v = {int'(irdy[1]), int'(ov[1]), act_od[7:0], occ_of(1)[2:0]};
         exp_v = {int'(q1.size() < 2), int'(q1.size() > 0), exp_od[7:0], 3'(q1.size())};
         chk("rand1", act_v, exp_v);
      end
      chk("conserve1", acc_cnt, out_cnt + occ_of(1));

      // STAGES=3 random traffic: ordering and occupancy against a queue
      acc_cnt = 0; out_cnt = 0;
      for (int c = 0; c < 500; c++) begin
         v = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 2) != 0);
         d = 8'($urandom);
         drive(3, v, d, r, 1'b0);
         #1;
         acc = v && irdy[3];
         pop = ov[3] && r;
         if (pop) begin
            if (q3.size() == 0) chk("rand3_pop_empty", 1, 0);
            else chk("rand3_order", int'(od[3]), int'(q3.pop_front()));
            out_cnt++;
         end
         if (acc) begin
            q3.push_back(d);
            acc_cnt++;
         end
         tick();
         chk("rand3_occ", occ_of(3), q3.size());
      end
      chk("conserve3", acc_cnt, out_cnt + occ_of(3));

      // asynchronous reset in the middle of traffic
      drive(1, 1'b1, 8'h61, 1'b0, 1'b0);
      drive(3, 1'b1, 8'h62, 1'b0, 1'b0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset(1, "mid_s1");
      chk_reset(3, "mid_s3");
      drive(1, 1'b1, 8'h77, 1'b1, 1'b0);
      tick();
      chk("mid_hold_occ", occ_of(1), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rel_ov", int'(ov[1]), 1);
      chk("rel_od", int'(od[1]), 8'h77);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
